axis_sample_capture: RTL and testbench
======================================

// Module: axis_sample_capture
// PURPOSE
//  AXI-Stream sink at the far end of the DDS->FIR chain: accepts the FIR's
//  m_axis_data stream (tvalid/tdata, 32-bit) and, once armed, records a
//  programmable number of consecutive samples into an on-chip buffer.
//  Captured data is then read back through a simple synchronous read port
//  by a host/ILA-style reader. Capture start is immediate or on a rising
//  zero-crossing of the signed sample.
// PARAMETERS
//  DATA_W   32    width of s_axis_data_tdata and of each stored word
//  DEPTH    1024  buffer depth in samples; power of two, >= 4
//  ADDR_W   10    log2(DEPTH); must equal $clog2(DEPTH)
// PORTS
//  aclk               in   1       single clock domain for all logic
//  aresetn            in   1       asynchronous, active-low reset
//  s_axis_data_tvalid in   1       sample valid from FIR output
//  s_axis_data_tready out  1       sink ready
//  s_axis_data_tdata  in   DATA_W  sample, two's complement
//  arm                in   1       1-cycle pulse: latch config, start capture
//  cfg_len            in   ADDR_W+1 samples to capture; 0 or >DEPTH => DEPTH
//  cfg_trig_zc        in   1       0 = start on first sample, 1 = zero-cross
//  busy               out  1       high in ARMED or CAPTURE
//  done               out  1       high in DONE until next arm
//  wr_count           out  ADDR_W+1 samples stored in current/last capture
//  rd_addr            in   ADDR_W  read address
//  rd_data            out  DATA_W  buffer word, valid 1 cycle after rd_addr
// BEHAVIOUR
//  - Reset (aresetn=0, async): state=IDLE, tready=0, busy=0, done=0,
//    wr_count=0, rd_data=0, prev-sample reg=0. Buffer contents undefined.
//  - tready=1 in every state once out of reset (sink never stalls the FIR);
//    beats outside CAPTURE are accepted and discarded. Beat = tvalid&tready.
//  - FSM: IDLE --arm--> ARMED; ARMED --trigger beat--> CAPTURE (that beat is
//    stored at addr 0); CAPTURE --last beat stored--> DONE; DONE --arm--> ARMED.
//  - arm in any state (incl. ARMED/CAPTURE) restarts: relatch cfg, wr_count=0,
//    done=0, state=ARMED next cycle; the beat in the arm cycle is discarded.
//  - Trigger: cfg_trig_zc=0 -> first beat in ARMED. cfg_trig_zc=1 -> beat
//    where prev<0 and cur>=0 (signed, DATA_W bits); prev tracks every beat
//    in all states, so a crossing spanning the arm cycle counts.
//  - Write: address = wr_count[ADDR_W-1:0]; wr_count increments per stored
//    beat; on store of beat number len (1-based) -> DONE same edge. Length
//    1 => single beat, ARMED->DONE directly.
//  - Read: registered, read-first; rd_data(t+1)=mem[rd_addr(t)] before any
//    write at edge t. Reads legal in any state.
//  - No wrap-around: writes never exceed len <= DEPTH.
// STRUCTURE
//  - Shared package dds_fir_pkg: capture state encoding (IDLE/ARMED/CAPTURE/
//    DONE, 2 bits), default DATA_W/DEPTH constants shared with DDS/FIR bench.
//  - Sub-module capture_ram: simple dual-port, 1 write port, 1 registered
//    read-first read port, DATA_W x DEPTH, inferred block RAM.
//  - Top: FSM, cfg latch, prev-sample reg, zero-cross compare, counter.
// TESTING
//  1 Reset mid-CAPTURE (after 5 beats, len=16) -> busy=0, done=0,
//    wr_count=0, tready=0 during reset, tready=1 one cycle after release.
//  2 cfg_len=8, trig_zc=0, arm, ramp tdata=100..115 every cycle -> done after
//    8th beat, wr_count=8, read addr 0..7 returns 101..108 (beat after arm).
//  3 trig_zc=1, stream -3,-2,-1,0,1,... len=4 -> mem[0..3]=0,1,2,3.
//  4 tvalid gaps (valid 1-0-0-1 pattern), len=4 -> only valid beats stored,
//    done after 4th valid beat; tready stays 1 throughout.
//  5 Re-arm at wr_count=3 of len=10 -> wr_count=0, state ARMED, next 10
//    beats overwrite from addr 0; cfg_len=0 -> captures 1024 samples.
//  6 Read addr 5 in the cycle its write occurs -> old data, then new data.

Source files
------------

// File: rtl/dds_fir_pkg.sv
// Shared definitions for the DDS->FIR chain: default datapath sizes and the
// sample-capture state encoding.
package dds_fir_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port and one registered,
// read-first read port, shaped for block-RAM inference.
module capture_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register only is reset; a same-edge write is not visible until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_sample_capture.sv
// AXI-Stream capture sink: once armed, stores a programmable run of samples,
// starting immediately or on a rising zero-crossing, for later readback.
module axis_sample_capture
  import dds_fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  input  logic [DATA_W-1:0] s_axis_data_tdata,
  input  logic              arm,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cfg_trig_zc,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic [ADDR_W:0] eff_len(input logic [ADDR_W:0] len);
    if (len == '0 || len > DEPTH_L) return DEPTH_L;
    else                            return len;
  endfunction

  cap_state_t      state;
  logic [ADDR_W:0] len_q;
  logic            trig_zc_q;
  // Only the sign of the previous beat matters for the crossing test.
  logic            prev_neg_p0;

  logic            beat;
  logic            zc_hit;
  logic            trig;
  logic            wr_en;
  logic [ADDR_W:0] wr_count_nxt;
  logic            last_beat;

  assign beat         = s_axis_data_tvalid & s_axis_data_tready;
  assign zc_hit       = prev_neg_p0 & ~s_axis_data_tdata[DATA_W-1];
  assign trig         = beat & (~trig_zc_q | zc_hit);
  assign wr_en        = ~arm & (((state == ST_ARMED) & trig) |
                                ((state == ST_CAPTURE) & beat));
  assign wr_count_nxt = wr_count + 1'b1;
  assign last_beat    = (wr_count_nxt == len_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state              <= ST_IDLE;
      s_axis_data_tready <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      wr_count           <= '0;
      len_q              <= '0;
      trig_zc_q          <= 1'b0;
      prev_neg_p0        <= 1'b0;
    end else begin
      s_axis_data_tready <= 1'b1;
      if (beat) prev_neg_p0 <= s_axis_data_tdata[DATA_W-1];
      // Arm wins over any store in the same cycle and restarts from scratch.
      if (arm) begin
        state     <= ST_ARMED;
        len_q     <= eff_len(cfg_len);
        trig_zc_q <= cfg_trig_zc;
        wr_count  <= '0;
        busy      <= 1'b1;
        done      <= 1'b0;
      end else if (wr_en) begin
        wr_count <= wr_count_nxt;
        if (last_beat) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= ST_CAPTURE;
        end
      end
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (wr_en),
    .waddr (wr_count[ADDR_W-1:0]),
    .wdata (s_axis_data_tdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_axis_sample_capture.sv
// Bench for axis_sample_capture: behavioural capture model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_axis_sample_capture;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              arm;
  logic [ADDR_W:0]   cfg_len;
  logic              cfg_trig_zc;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  always #5 aclk = ~aclk;

  axis_sample_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tvalid (tvalid),
    .s_axis_data_tready (tready),
    .s_axis_data_tdata  (tdata),
    .arm                (arm),
    .cfg_len            (cfg_len),
    .cfg_trig_zc        (cfg_trig_zc),
    .busy               (busy),
    .done               (done),
    .wr_count           (wr_count),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 waiting for trigger, 2 recording, 3 finished.
  int                m_mode;
  bit                m_tready;
  int                m_len;
  bit                m_zc;
  int                m_cnt;
  int                m_prev;
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_ok  [DEPTH];
  logic [DATA_W-1:0] m_rd;
  bit                m_rd_ok;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_tready = 1'b0;
    m_cnt    = 0;
    m_prev   = 0;
    m_rd     = '0;
    m_rd_ok  = 1'b1;
  endtask

  task automatic model_update();
    bit mb;
    int cur;
    bit store;
    mb  = tvalid && m_tready;
    cur = int'($signed(tdata));
    m_rd    = m_mem[rd_addr];
    m_rd_ok = m_ok[rd_addr];
    store = 1'b0;
    if (arm) begin
      m_mode = 1;
      m_len  = (cfg_len == 0 || int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
      m_zc   = cfg_trig_zc;
      m_cnt  = 0;
    end else if (mb) begin
      if (m_mode == 2) store = 1'b1;
      if (m_mode == 1 && (!m_zc || (m_prev < 0 && cur >= 0))) store = 1'b1;
    end
    if (store) begin
      m_mem[m_cnt] = tdata;
      m_ok[m_cnt]  = 1'b1;
      m_cnt++;
      m_mode = (m_cnt == m_len) ? 3 : 2;
    end
    if (mb) m_prev = cur;
    m_tready = 1'b1;
  endtask

  task automatic compare();
    chk("tready",   longint'(tready),   longint'(m_tready));
    chk("busy",     longint'(busy),     longint'(m_mode == 1 || m_mode == 2));
    chk("done",     longint'(done),     longint'(m_mode == 3));
    chk("wr_count", longint'(wr_count), longint'(m_cnt));
    if (m_rd_ok) chk("rd_data", longint'(rd_data), longint'(m_rd));
  endtask

  task automatic step();
    @(posedge aclk);
    if (aresetn) model_update();
    @(negedge aclk);
    compare();
  endtask

  task automatic drv(input bit v, input int d, input bit a);
    tvalid = v;
    tdata  = DATA_W'(d);
    arm    = a;
  endtask

  task automatic read_lit(input string name, input int addr, input int exp);
    drv(1'b0, 0, 1'b0);
    rd_addr = ADDR_W'(addr);
    step();
    chk(name, longint'(rd_data), longint'(exp));
  endtask

  int done_at;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_ok[i] = 1'b0;
    aresetn = 1'b0; tvalid = 1'b0; tdata = '0; arm = 1'b0;
    cfg_len = '0; cfg_trig_zc = 1'b0; rd_addr = '0;
    model_reset();
    repeat (3) step();
    aresetn = 1'b1;
    step();

    // Reset in the middle of a capture.
    cfg_len = 11'd16; cfg_trig_zc = 1'b0;
    drv(1'b1, 50, 1'b1); step();
    for (int i = 1; i <= 5; i++) begin drv(1'b1, 50 + i, 1'b0); step(); end
    chk("t1_wr_count_pre", longint'(wr_count), 5);
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("t1_busy_rst",   longint'(busy), 0);
    chk("t1_done_rst",   longint'(done), 0);
    chk("t1_wcnt_rst",   longint'(wr_count), 0);
    chk("t1_tready_rst", longint'(tready), 0);
    drv(1'b0, 0, 1'b0);
    repeat (2) step();
    aresetn = 1'b1;
    #1;
    chk("t1_tready_release", longint'(tready), 0);
    step();
    chk("t1_tready_after", longint'(tready), 1);

    // Ramp capture, immediate trigger; arm-cycle beat is dropped.
    cfg_len = 11'd8; cfg_trig_zc = 1'b0;
    drv(1'b1, 100, 1'b1); step();
    for (int i = 1; i <= 15; i++) begin
      drv(1'b1, 100 + i, 1'b0); step();
      if (i == 7) chk("t2_done_early", longint'(done), 0);
      if (i == 8) begin
        chk("t2_done", longint'(done), 1);
        chk("t2_wr_count", longint'(wr_count), 8);
      end
    end
    for (int k = 0; k < 8; k++) read_lit("t2_rd", k, 101 + k);

    // Rising zero-crossing trigger.
    cfg_len = 11'd4; cfg_trig_zc = 1'b1;
    drv(1'b1, -5, 1'b1); step();
    for (int i = -3; i <= 5; i++) begin drv(1'b1, i, 1'b0); step(); end
    chk("t3_done", longint'(done), 1);
    for (int k = 0; k < 4; k++) read_lit("t3_rd", k, k);

    // Valid gaps: only real beats count.
    cfg_len = 11'd4; cfg_trig_zc = 1'b0;
    drv(1'b0, 0, 1'b1); step();
    for (int i = 0; i < 12; i++) begin
      drv((i % 3) == 0, 500 + i, 1'b0); step();
      chk("t4_tready", longint'(tready), 1);
      if (i == 8) chk("t4_done_early", longint'(done), 0);
      if (i == 9) chk("t4_done", longint'(done), 1);
    end
    for (int k = 0; k < 4; k++) read_lit("t4_rd", k, 500 + 3 * k);

    // Re-arm mid-capture, then full-depth capture with cfg_len=0.
    cfg_len = 11'd10; cfg_trig_zc = 1'b0;
    drv(1'b1, 599, 1'b1); step();
    for (int i = 0; i < 3; i++) begin drv(1'b1, 600 + i, 1'b0); step(); end
    chk("t5_wcnt3", longint'(wr_count), 3);
    drv(1'b1, 700, 1'b1); step();
    chk("t5_rearm_wcnt", longint'(wr_count), 0);
    chk("t5_rearm_busy", longint'(busy), 1);
    for (int i = 1; i <= 10; i++) begin drv(1'b1, 700 + i, 1'b0); step(); end
    chk("t5_done10", longint'(done), 1);
    read_lit("t5_rd0", 0, 701);
    read_lit("t5_rd9", 9, 710);
    cfg_len = 11'd0;
    drv(1'b1, 0, 1'b1); step();
    done_at = -1;
    for (int i = 1; i <= 1100 && done_at < 0; i++) begin
      drv(1'b1, i, 1'b0); step();
      if (done) done_at = i;
    end
    chk("t5_full_beats", longint'(done_at), 1024);
    chk("t5_full_wcnt", longint'(wr_count), 1024);
    read_lit("t5_rd1023", 1023, 1024);

    // Read-first collision at address 5.
    cfg_len = 11'd8; cfg_trig_zc = 1'b0; rd_addr = 10'd5;
    drv(1'b1, 200, 1'b1); step();
    for (int i = 1; i <= 7; i++) begin
      drv(1'b1, 200 + i, 1'b0); step();
      if (i == 6) chk("t6_old", longint'(rd_data), 6);
      if (i == 7) chk("t6_new", longint'(rd_data), 206);
    end

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg_len     = ($urandom_range(0, 19) == 0) ? 11'($urandom_range(1000, 2047))
                                                   : 11'($urandom_range(0, 12));
        cfg_trig_zc = 1'($urandom_range(0, 1));
        arm = 1'b1;
      end else begin
        arm = 1'b0;
      end
      tvalid  = ($urandom_range(0, 3) != 0);
      tdata   = DATA_W'(int'($urandom_range(0, 16)) - 8);
      rd_addr = ADDR_W'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
